// File: rtl/mem_copy_dma.sv
// Word-by-word memory copy engine: reads one 32-bit word from the source and
// then writes it to the destination, for word_count words.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; all outputs quiet
// READ  | mem_rd=1 at src pointer; read data captured into the buffer
// WRITE | mem_wr=1 at dst pointer with buffered data; pointers advance
// DONE  | one-cycle done pulse, no memory access
// ERR   | one-cycle err pulse for a misaligned request, no memory access
module mem_copy_dma #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      src_adr,
    input  logic [31:0]      dst_adr,
    input  logic [CNT_W-1:0] word_count,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [31:0]      mem_adr,
    output logic [31:0]      mem_wdata,
    output logic             mem_rd,
    output logic             mem_wr,
    input  logic [31:0]      mem_rdata
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [31:0]      src_ptr;
    logic [31:0]      dst_ptr;
    logic [CNT_W-1:0] remaining;
    logic [31:0]      buffer;
    logic             misaligned;
    logic             last_word;

    assign misaligned = (src_adr[1:0] != 2'b00) || (dst_adr[1:0] != 2'b00);
    assign last_word  = (remaining == CNT_W'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    // Alignment faults take precedence over a zero-length request.
                    if (misaligned) begin
                        state_nxt = ERR;
                    end else if (word_count == '0) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = READ;
                    end
                end
            end
            READ:    state_nxt = WRITE;
            WRITE:   state_nxt = last_word ? DONE : READ;
            DONE:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src_ptr   <= '0;
            dst_ptr   <= '0;
            remaining <= '0;
            buffer    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        src_ptr   <= src_adr;
                        dst_ptr   <= dst_adr;
                        remaining <= word_count;
                    end
                end
                READ: begin
                    buffer <= mem_rdata;
                end
                WRITE: begin
                    src_ptr   <= src_ptr + 32'd4;
                    dst_ptr   <= dst_ptr + 32'd4;
                    remaining <= remaining - CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs depend on the state register and datapath registers only.
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        mem_adr   = '0;
        mem_wdata = '0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        case (state)
            READ: begin
                busy    = 1'b1;
                mem_rd  = 1'b1;
                mem_adr = src_ptr;
            end
            WRITE: begin
                busy      = 1'b1;
                mem_wr    = 1'b1;
                mem_adr   = dst_ptr;
                mem_wdata = buffer;
            end
            DONE:    done = 1'b1;
            ERR:     err  = 1'b1;
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_copy_dma.sv
// Bench for mem_copy_dma: a 4 KB word memory plus a shadow copy that models
// the forward word copy, checked cycle by cycle and by full memory compare.
module tb_mem_copy_dma;

    localparam int CW = 4;

    logic          clk;
    logic          rst;
    logic          start;
    logic [31:0]   src_adr;
    logic [31:0]   dst_adr;
    logic [CW-1:0] word_count;
    logic          busy;
    logic          done;
    logic          err;
    logic [31:0]   mem_adr;
    logic [31:0]   mem_wdata;
    logic          mem_rd;
    logic          mem_wr;
    logic [31:0]   mem_rdata;

    logic [31:0] mem  [0:1023];
    logic [31:0] refm [0:1023];
    logic        ld_en;
    logic [9:0]  ld_idx;
    logic [31:0] ld_data;

    int n_checks = 0;
    int n_errors = 0;

    mem_copy_dma #(.CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .src_adr    (src_adr),
        .dst_adr    (dst_adr),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .mem_adr    (mem_adr),
        .mem_wdata  (mem_wdata),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_rdata  (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign mem_rdata = mem[mem_adr[11:2]];

    always @(posedge clk) begin
        if (ld_en) begin
            mem[ld_idx] <= ld_data;
        end else if (mem_wr) begin
            mem[mem_adr[11:2]] <= mem_wdata;
        end
    end

    function automatic logic [9:0] idx(input logic [31:0] a);
        return a[11:2];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " done"}, 32'(done), 32'd0);
        check({tag, " err"}, 32'(err), 32'd0);
        check({tag, " rd"}, 32'(mem_rd), 32'd0);
        check({tag, " wr"}, 32'(mem_wr), 32'd0);
        check({tag, " adr"}, mem_adr, 32'd0);
        check({tag, " wdata"}, mem_wdata, 32'd0);
    endtask

    task automatic load_word(input int i, input logic [31:0] v);
        ld_en   = 1'b1;
        ld_idx  = 10'(i);
        ld_data = v;
        @(posedge clk);
        #1;
        ld_en   = 1'b0;
        refm[i] = v;
    endtask

    task automatic mem_compare(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < 1024; i++) begin
            if (mem[i] !== refm[i]) bad++;
        end
        check({tag, " mem_diff_words"}, 32'(bad), 32'd0);
    endtask

    // One request from IDLE. poke: cycle after E to re-pulse start (0 = none).
    // rstk: READ cycle in which reset is asserted between edges (0 = none).
    task automatic run_copy(input logic [31:0] src, input logic [31:0] dst, input int cnt,
                            input int poke, input int rstk);
        logic        bad;
        bit          fin;
        int          w;
        logic [31:0] sa;
        logic [31:0] da;
        logic [31:0] val;
        bad = (src[1:0] != 2'b00) || (dst[1:0] != 2'b00);
        src_adr    = src;
        dst_adr    = dst;
        word_count = CW'(cnt);
        start      = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        src_adr    = $urandom;
        dst_adr    = $urandom;
        word_count = CW'($urandom);
        fin = 1'b0;
        for (int k = 1; k <= 2 * cnt + 4 && !fin; k++) begin
            w  = (k - 1) / 2;
            sa = src + 32'(4 * w);
            da = dst + 32'(4 * w);
            if (bad) begin
                if (k == 1) begin
                    check("err pulse", 32'(err), 32'd1);
                    check("err rd", 32'(mem_rd), 32'd0);
                    check("err wr", 32'(mem_wr), 32'd0);
                    check("err busy", 32'(busy), 32'd0);
                    check("err done", 32'(done), 32'd0);
                end else begin
                    check_idle("after err");
                    fin = 1'b1;
                end
            end else if (k <= 2 * cnt) begin
                if (k % 2 == 1) begin
                    check("read rd", 32'(mem_rd), 32'd1);
                    check("read wr", 32'(mem_wr), 32'd0);
                    check("read adr", mem_adr, sa);
                    check("read busy", 32'(busy), 32'd1);
                    check("read done", 32'(done), 32'd0);
                    if (k == rstk) begin
                        #2;
                        rst = 1'b0;
                        #1;
                        check_idle("async rst");
                        @(posedge clk);
                        #1;
                        check_idle("rst held");
                        rst = 1'b1;
                        @(posedge clk);
                        #1;
                        check_idle("rst released");
                        fin = 1'b1;
                    end
                end else begin
                    val = refm[idx(sa)];
                    check("write wr", 32'(mem_wr), 32'd1);
                    check("write rd", 32'(mem_rd), 32'd0);
                    check("write adr", mem_adr, da);
                    check("write data", mem_wdata, val);
                    check("write busy", 32'(busy), 32'd1);
                    refm[idx(da)] = val;
                end
            end else if (k == 2 * cnt + 1) begin
                check("done pulse", 32'(done), 32'd1);
                check("done busy", 32'(busy), 32'd0);
                check("done rd", 32'(mem_rd), 32'd0);
                check("done wr", 32'(mem_wr), 32'd0);
                check("done err", 32'(err), 32'd0);
            end else begin
                check_idle("after done");
                fin = 1'b1;
            end
            start = (k == poke);
            if (!fin) begin
                @(posedge clk);
                #1;
            end
        end
        start = 1'b0;
        if (!fin) check("timeout", 32'd0, 32'd1);
        mem_compare("copy");
    endtask

    initial begin
        int          cnt;
        int          poke;
        logic [31:0] s;
        logic [31:0] d;
        rst        = 1'b0;
        start      = 1'b0;
        src_adr    = '0;
        dst_adr    = '0;
        word_count = '0;
        ld_en      = 1'b0;
        ld_idx     = '0;
        ld_data    = '0;
        #3;
        check_idle("reset");
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset with start");
        start = 1'b0;
        rst   = 1'b1;
        @(posedge clk);
        #1;
        check_idle("idle");

        for (int i = 0; i < 1024; i++) load_word(i, $urandom);

        // Directed 4-word copy 1000 -> 2000.
        for (int i = 0; i < 4; i++) load_word(250 + i, 32'(i + 1));
        run_copy(32'd1000, 32'd2000, 4, 0, 0);
        for (int i = 0; i < 4; i++) check("dst word", mem[500 + i], 32'(i + 1));
        check("dst byte 2000", 32'(mem[500][7:0]), 32'd1);

        // Restart pulse during WRITE of word 2 is ignored.
        for (int i = 0; i < 4; i++) load_word(500 + i, 32'd0);
        run_copy(32'd1000, 32'd2000, 4, 4, 0);

        run_copy(32'd1000, 32'd2000, 0, 0, 0);
        run_copy(32'd1001, 32'd2000, 3, 0, 0);
        run_copy(32'd1000, 32'd2002, 3, 0, 0);

        // Reset during READ of word 3: words 1-2 land, 3-4 untouched.
        for (int i = 0; i < 4; i++) load_word(500 + i, 32'd0);
        run_copy(32'd1000, 32'd2000, 4, 0, 5);
        check("abort word1", mem[500], 32'd1);
        check("abort word2", mem[501], 32'd2);
        check("abort word3", mem[502], 32'd0);
        check("abort word4", mem[503], 32'd0);
        run_copy(32'd1000, 32'd2000, 4, 0, 0);

        run_copy(32'hFFFF_FFFC, 32'd100, 2, 0, 0);
        run_copy(32'd400, 32'd3000, (1 << CW) - 1, 0, 0);
        run_copy(32'd1000, 32'd1008, 6, 0, 0);

        for (int t = 0; t < 30; t++) begin
            cnt = int'($urandom_range(0, (1 << CW) - 1));
            s   = {$urandom_range(0, 1) == 1 ? 20'hFFFFF : 20'h0, 12'($urandom) & 12'hFFC};
            d   = {20'h0, 12'($urandom) & 12'hFFC};
            if ($urandom_range(0, 5) == 0) s[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 5) == 0) d[1:0] = 2'($urandom_range(1, 3));
            poke = (cnt > 0 && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, 2 * cnt)) : 0;
            run_copy(s, d, cnt, poke, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_copy_dma.md
MEM_COPY_DMA -- requirements
Module: mem_copy_dma

Interface
REQ-001 Parameter CNT_W, default 16: width of the word-count operand and the internal remaining-words counter.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low; asserted when 0.
REQ-004 start  input  1  one-cycle request; sampled only in IDLE.
REQ-005 src_adr  input  32  byte address of the first source word.
REQ-006 dst_adr  input  32  byte address of the first destination word.
REQ-007 word_count  input  CNT_W  number of 32-bit words to copy.
REQ-008 busy  output  1  high while a transfer is in READ or WRITE.
REQ-009 done  output  1  one-cycle pulse at normal completion.
REQ-010 err  output  1  one-cycle pulse when a request is rejected.
REQ-011 mem_adr  output  32  byte address to memory (memory adr port).
REQ-012 mem_wdata  output  32  write data to memory (memory d_in port).
REQ-013 mem_rd  output  1  memory read enable (memory mrd port).
REQ-014 mem_wr  output  1  memory write enable (memory mwr port).
REQ-015 mem_rdata  input  32  read data from memory (memory d_out port); valid combinationally in the same cycle as mem_rd=1.

Function
REQ-016 Block SHALL be the initiator for the existing byte-addressed little-endian word memory: combinational read while mrd=1, word write at the rising clk edge while mwr=1.
REQ-017 FSM states SHALL be IDLE, READ, WRITE, DONE, ERR; all memory-side outputs SHALL be decoded from state and registers only (Moore), with no combinational path from start to any memory-side output.
REQ-018 IDLE: mem_rd=mem_wr=0, mem_adr=0, mem_wdata=0, busy=0, done=0, err=0.
REQ-019 IDLE with start=1: latch src_adr, dst_adr, word_count into the src pointer, dst pointer and remaining counter.
REQ-020 Start dispatch SHALL use this precedence: if src_adr[1:0]!=0 or dst_adr[1:0]!=0, go to ERR; else if word_count=0, go to DONE; else go to READ.
REQ-021 ERR SHALL last one cycle with err=1, generate no memory access, then return to IDLE.
REQ-022 READ: mem_rd=1, mem_wr=0, mem_adr=src pointer, busy=1; at the clock edge, capture mem_rdata into the 32-bit data buffer and go to WRITE.
REQ-023 WRITE: mem_wr=1, mem_rd=0, mem_adr=dst pointer, mem_wdata=buffer, busy=1.
REQ-024 At the WRITE clock edge: src and dst pointers each += 4 (mod 2^32, wrap silently) and remaining -= 1; if the old remaining was 1, go to DONE, else go to READ.
REQ-025 DONE: done=1 for exactly one cycle with no memory access, then return to IDLE.
REQ-026 Latency: start accepted at edge E, first READ in cycle E+1, done high in cycle E+2N+1 for N>=1; a zero-count request gives done in cycle E+1.
REQ-027 start SHALL be ignored in READ, WRITE, DONE and ERR; operands are not re-sampled mid-transfer.
REQ-028 Copy SHALL be strictly forward, word by word; overlapping regions with dst>src SHALL propagate already-written words (defined, not an error).
REQ-029 word_count = 2^CNT_W-1 SHALL copy exactly that many words with no counter overflow.

Reset
REQ-030 rst=0 SHALL force IDLE immediately, independent of clk, and clear the pointers, remaining counter and buffer to 0.
REQ-031 While rst=0, all outputs SHALL equal their IDLE values.
REQ-032 Reset asserted mid-transfer SHALL abort it with no done or err pulse; words already written stay written, and mem_wr SHALL be 0 at the next edge.
REQ-033 After reset release, the first start SHALL be accepted no earlier than the first rising edge with rst=1.

Verification
REQ-034 Preload words 1..4 at byte 1000; request src=1000, dst=2000, count=4 -> 8 alternating READ/WRITE cycles, done at cycle E+9, bytes 2000..2015 = 1,2,3,4 little-endian.
REQ-035 count=0 -> done at E+1; mem_rd and mem_wr stay 0 throughout.
REQ-036 src=1001, dst=2000, count=3 -> err at E+1; no memory access; then idle (busy=0, done=0, err=0).
REQ-037 Pulse start again during WRITE of word 2 of a 4-word copy -> ignored; same completion cycle and same data as REQ-034.
REQ-038 Assert rst=0 between edges during READ of word 3 of 4 -> outputs go to IDLE values at once; dst words 1-2 written, words 3-4 untouched; no done pulse.
REQ-039 src=0xFFFFFFFC, dst=100, count=2 -> second read address 0x00000000; done at E+5.
